// File: rtl/mmult_opt_mdc_in_join.sv
// ============================================================================
// Module   : mmult_opt_mdc_in_join
// Purpose  : Joins two operand streams through per-input FIFOs into one paired
//            stream, tracking beats per tile with last/done markers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmult_opt_mdc_in_join #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          enable_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  input  logic [DATA_WIDTH-1:0]         in1_data_i,
  input  logic                          in1_valid_i,
  output logic                          in1_ready_o,
  input  logic [DATA_WIDTH-1:0]         in2_data_i,
  input  logic                          in2_valid_i,
  output logic                          in2_ready_o,
  output logic [2*DATA_WIDTH-1:0]       out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic [LEN_WIDTH-1:0]          beat_cnt_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   in1_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   in2_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem1 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem2 [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr1, rd1, wr2, rd2;
  logic [LVL_W-1:0]      lvl1, lvl2;
  logic [LEN_WIDTH-1:0]  beat;
  logic                  done;

  logic                  push1, push2, pop;
  logic [LEN_WIDTH-1:0]  eff_len;

  // Ready depends only on registered occupancy, never on the downstream ready.
  assign in1_ready_o = (lvl1 != FULL_LVL);
  assign in2_ready_o = (lvl2 != FULL_LVL);
  assign push1       = in1_valid_i && in1_ready_o;
  assign push2       = in2_valid_i && in2_ready_o;

  assign out_valid_o = enable_i && (lvl1 != '0) && (lvl2 != '0);
  assign out_data_o  = {mem2[rd2], mem1[rd1]};
  assign pop         = out_valid_o && out_ready_i;

  assign eff_len     = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
  assign out_last_o  = out_valid_o && (beat == eff_len - LEN_WIDTH'(1));

  assign beat_cnt_o  = beat;
  assign done_o      = done;
  assign in1_level_o = lvl1;
  assign in2_level_o = lvl2;

  // Storage carries no reset; stale contents are never visible past the level.
  always_ff @(posedge clk_i) begin
    if (push1) mem1[wr1] <= in1_data_i;
    if (push2) mem2[wr2] <= in2_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr1  <= '0;
      rd1  <= '0;
      wr2  <= '0;
      rd2  <= '0;
      lvl1 <= '0;
      lvl2 <= '0;
      beat <= '0;
      done <= 1'b0;
    end else begin
      if (push1) wr1 <= wr1 + PTR_W'(1);
      if (push2) wr2 <= wr2 + PTR_W'(1);
      if (pop) begin
        rd1 <= rd1 + PTR_W'(1);
        rd2 <= rd2 + PTR_W'(1);
      end

      case ({push1, pop})
        2'b10:   lvl1 <= lvl1 + LVL_W'(1);
        2'b01:   lvl1 <= lvl1 - LVL_W'(1);
        default: lvl1 <= lvl1;
      endcase
      case ({push2, pop})
        2'b10:   lvl2 <= lvl2 + LVL_W'(1);
        2'b01:   lvl2 <= lvl2 - LVL_W'(1);
        default: lvl2 <= lvl2;
      endcase

      if (pop) beat <= out_last_o ? '0 : beat + LEN_WIDTH'(1);
      done <= pop && out_last_o;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmult_opt_mdc_in_join.sv
// ============================================================================
// Module   : tb_mmult_opt_mdc_in_join
// Purpose  : Directed self-checking bench for the operand join block.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmult_opt_mdc_in_join;

  localparam int DW = 32;
  localparam int FD = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          enable_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [DW-1:0] in1_data_i = '0;
  logic          in1_valid_i = 1'b0;
  logic          in1_ready_o;
  logic [DW-1:0] in2_data_i = '0;
  logic          in2_valid_i = 1'b0;
  logic          in2_ready_o;
  logic [2*DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic          out_last_o;
  logic [LW-1:0] beat_cnt_o;
  logic          done_o;
  logic [2:0]    in1_level_o;
  logic [2:0]    in2_level_o;

  int vectors = 0;
  int errors  = 0;

  mmult_opt_mdc_in_join #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i), .len_i(len_i),
    .in1_data_i(in1_data_i), .in1_valid_i(in1_valid_i), .in1_ready_o(in1_ready_o),
    .in2_data_i(in2_data_i), .in2_valid_i(in2_valid_i), .in2_ready_o(in2_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .beat_cnt_o(beat_cnt_o), .done_o(done_o),
    .in1_level_o(in1_level_o), .in2_level_o(in2_level_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_i = 1'b1; clear_i = 1'b0;
    in1_valid_i = 1'b0; in2_valid_i = 1'b0; out_ready_i = 1'b0;
    cyc();
    rst_i = 1'b0;
  endtask

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];

  initial begin
    // ---------------- reset state
    cyc(); cyc();
    rst_i = 1'b0;
    settle();
    chk("rst_lvl1",  64'(in1_level_o), 64'd0);
    chk("rst_lvl2",  64'(in2_level_o), 64'd0);
    chk("rst_rdy1",  64'(in1_ready_o), 64'd1);
    chk("rst_rdy2",  64'(in2_ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_last",  64'(out_last_o),  64'd0);
    chk("rst_beat",  64'(beat_cnt_o),  64'd0);
    chk("rst_done",  64'(done_o),      64'd0);

    // ---------------- basic pair, len 4
    len_i = 16'd4; enable_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i <= 4) begin
        in1_valid_i = 1'b1; in2_valid_i = 1'b1;
        in1_data_i = DW'(i); in2_data_i = DW'(10 * i);
      end else begin
        in1_valid_i = 1'b0; in2_valid_i = 1'b0;
      end
      settle();
      if (i == 1) chk("basic_empty_valid", 64'(out_valid_o), 64'd0);
      else begin
        chk("basic_valid", 64'(out_valid_o), 64'd1);
        chk("basic_data",  out_data_o, {32'(10 * (i - 1)), 32'(i - 1)});
        chk("basic_last",  64'(out_last_o), 64'(i == 5));
        chk("basic_beat",  64'(beat_cnt_o), 64'(i - 2));
        chk("basic_done_early", 64'(done_o), 64'd0);
      end
    end
    cyc(); settle();
    chk("basic_done",     64'(done_o),      64'd1);
    chk("basic_beat_wrap", 64'(beat_cnt_o), 64'd0);
    chk("basic_valid_off", 64'(out_valid_o), 64'd0);
    cyc(); settle();
    chk("basic_done_once", 64'(done_o), 64'd0);

    // ---------------- skew and backpressure
    do_reset();
    out_ready_i = 1'b0; enable_i = 1'b1; len_i = 16'd4;
    for (int i = 0; i < 4; i++) begin
      cyc();
      in1_valid_i = 1'b1; in1_data_i = DW'(100 + i);
    end
    cyc();
    in1_valid_i = 1'b0;
    settle();
    chk("skew_lvl1_full", 64'(in1_level_o), 64'd4);
    chk("skew_rdy1_low",  64'(in1_ready_o), 64'd0);
    chk("skew_valid_low", 64'(out_valid_o), 64'd0);
    in2_valid_i = 1'b1; in2_data_i = 32'd200;
    cyc();
    in2_valid_i = 1'b0; in2_data_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("skew_valid_hold", 64'(out_valid_o), 64'd1);
      chk("skew_data_hold",  out_data_o, {32'd200, 32'd100});
      cyc();
    end
    out_ready_i = 1'b1;
    settle();
    chk("skew_data_pop", out_data_o, {32'd200, 32'd100});
    cyc();
    out_ready_i = 1'b0;
    settle();
    chk("skew_lvl1_after", 64'(in1_level_o), 64'd3);
    chk("skew_lvl2_after", 64'(in2_level_o), 64'd0);
    chk("skew_valid_after", 64'(out_valid_o), 64'd0);
    chk("skew_beat_after", 64'(beat_cnt_o), 64'd1);

    // ---------------- enable low fill, then full simultaneous push/pop
    do_reset();
    len_i = 16'd16; out_ready_i = 1'b1;
    q1.delete(); q2.delete();
    begin
      int pops = 0;
      for (int c = 0; c < 25; c++) begin
        logic mv, p1, p2;
        cyc();
        enable_i = (c >= 5);
        in1_valid_i = 1'b1; in2_valid_i = 1'b1;
        in1_data_i = DW'(c); in2_data_i = DW'(c + 500);
        settle();
        mv = enable_i && q1.size() != 0 && q2.size() != 0;
        chk("full_lvl1",  64'(in1_level_o), 64'(q1.size()));
        chk("full_lvl2",  64'(in2_level_o), 64'(q2.size()));
        chk("full_rdy1",  64'(in1_ready_o), 64'(q1.size() != FD));
        chk("full_valid", 64'(out_valid_o), 64'(mv));
        chk("full_beat",  64'(beat_cnt_o),  64'(pops % 16));
        chk("full_last",  64'(out_last_o),  64'(mv && (pops % 16) == 15));
        if (mv) chk("full_data", out_data_o, {q2[0], q1[0]});
        p1 = q1.size() != FD;
        p2 = q2.size() != FD;
        if (mv) begin
          void'(q1.pop_front()); void'(q2.pop_front()); pops++;
        end
        if (p1) q1.push_back(DW'(c));
        if (p2) q2.push_back(DW'(c + 500));
      end
      chk("full_pop_count", 64'(pops), 64'd20);
    end
    in1_valid_i = 1'b0; in2_valid_i = 1'b0;

    // ---------------- len 0: every pair is last
    do_reset();
    len_i = 16'd0; enable_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      in1_valid_i = (i <= 3); in2_valid_i = (i <= 3);
      in1_data_i = DW'(i); in2_data_i = DW'(i + 7);
      settle();
      chk("len0_valid", 64'(out_valid_o), 64'(i >= 2 && i <= 4));
      chk("len0_last",  64'(out_last_o),  64'(i >= 2 && i <= 4));
      chk("len0_beat",  64'(beat_cnt_o),  64'd0);
      chk("len0_done",  64'(done_o),      64'(i >= 3));
    end

    // ---------------- clear mid-tile, then a full len 8 tile
    do_reset();
    len_i = 16'd8; enable_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      in1_valid_i = 1'b1; in2_valid_i = 1'b1;
      in1_data_i = DW'(i); in2_data_i = DW'(i + 50);
      clear_i = (i == 5);
      settle();
      if (i == 5) chk("clr_beat_before", 64'(beat_cnt_o), 64'd3);
    end
    cyc();
    clear_i = 1'b0; in1_valid_i = 1'b0; in2_valid_i = 1'b0;
    settle();
    chk("clr_lvl1",  64'(in1_level_o), 64'd0);
    chk("clr_lvl2",  64'(in2_level_o), 64'd0);
    chk("clr_beat",  64'(beat_cnt_o),  64'd0);
    chk("clr_done",  64'(done_o),      64'd0);
    chk("clr_valid", 64'(out_valid_o), 64'd0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      in1_valid_i = (i <= 8); in2_valid_i = (i <= 8);
      in1_data_i = DW'(19 + i); in2_data_i = DW'(69 + i);
      settle();
      chk("tile_done_low", 64'(done_o), 64'd0);
      if (i >= 2) begin
        chk("tile_data", out_data_o, {32'(69 + i - 1), 32'(19 + i - 1)});
        chk("tile_beat", 64'(beat_cnt_o), 64'(i - 2));
        chk("tile_last", 64'(out_last_o), 64'(i == 9));
      end
    end
    cyc(); settle();
    chk("tile_done", 64'(done_o), 64'd1);
    chk("tile_beat_wrap", 64'(beat_cnt_o), 64'd0);

    // ---------------- reset during backpressure with 2 entries each
    do_reset();
    len_i = 16'd4; enable_i = 1'b1; out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      in1_valid_i = 1'b1; in2_valid_i = 1'b1;
      in1_data_i = DW'(i); in2_data_i = DW'(i);
    end
    cyc();
    settle();
    chk("bp_lvl1", 64'(in1_level_o), 64'd2);
    chk("bp_valid", 64'(out_valid_o), 64'd1);
    rst_i = 1'b1; clear_i = 1'b1; out_ready_i = 1'b1;
    cyc();
    rst_i = 1'b0; clear_i = 1'b0;
    in1_valid_i = 1'b0; in2_valid_i = 1'b0;
    settle();
    chk("bprst_lvl1",  64'(in1_level_o), 64'd0);
    chk("bprst_lvl2",  64'(in2_level_o), 64'd0);
    chk("bprst_rdy1",  64'(in1_ready_o), 64'd1);
    chk("bprst_rdy2",  64'(in2_ready_o), 64'd1);
    chk("bprst_valid", 64'(out_valid_o), 64'd0);
    chk("bprst_last",  64'(out_last_o),  64'd0);
    chk("bprst_beat",  64'(beat_cnt_o),  64'd0);
    chk("bprst_done",  64'(done_o),      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
